// File: rtl/nibser_pkg.sv
// Shared state encodings and nibble helpers for the nibble-serial add/sub unit.
package nibser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int NIB_W = 4;

  function automatic int nibbles(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/clas_4bit.sv
// 4-bit carry-lookahead add/sub slice; combinational, no backpressure.
// sel inverts b; the caller supplies c_in (sel on the first nibble, carry after).
module clas_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sel,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] beff;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    beff = b ^ {4{sel}};
    g    = a & beff;
    p    = a ^ beff;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum   = p ^ c[3:0];
    c_out = c[4];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/sub reusing one 4-bit slice, LSB nibble first; result valid NIBBLES cycles after accept,
// held in DONE until out_ready. NIBSER_EARLY_ACCEPT_EN allows accepting the next op on the handoff edge.
module nibble_serial_addsub
  import nibser_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int IDX_W   = $clog2(NIBBLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               sel_q, sel_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [NIB_W-1:0]   a_nib;
  logic [NIB_W-1:0]   b_nib;
  logic [NIB_W-1:0]   sum_nib;
  logic               slice_c;
  logic               accept;
  logic               last_nib;

  clas_4bit u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .sel   (sel_q),
    .c_in  (carry_q),
    .sum   (sum_nib),
    .c_out (slice_c)
  );

`ifdef NIBSER_EARLY_ACCEPT_EN
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign accept   = in_valid && in_ready;
  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) result_d[i*NIB_W +: NIB_W] = sum_nib;
        end
        carry_d = slice_c;
        if (last_nib) begin
          state_d     = DONE;
          c_out_d     = slice_c;
          ovf_d       = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sel_q)) && (sum_nib[NIB_W-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept only happens in IDLE or (early mode) on the DONE handoff edge.
    if (accept) begin
      state_d     = RUN;
      a_d         = a;
      b_d         = b;
      sel_d       = sel;
      carry_d     = sel;
      idx_d       = '0;
      result_d    = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sel_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomized and directed bench for nibble_serial_addsub (WIDTH=16) against an arithmetic model.
module tb_nibble_serial_addsub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sel = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msel);
    int ia, ib, s;
    logic [W-1:0] r;
    logic c, v;
    ia = int'($signed(ma));
    ib = int'($signed(mb));
    if (!msel) begin
      r = ma + mb;
      c = (int'(ma) + int'(mb)) > 65535;
      s = ia + ib;
    end else begin
      r = ma - mb;
      c = (ma >= mb);
      s = ia - ib;
    end
    v = (s > 32767) || (s < -32768);
    return {v, c, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation and collects its outputs (no comparisons here).
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osel,
                        output logic [W-1:0] r, output logic c, output logic v, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    a = oa; b = ob; sel = osel; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sel = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    r = result; c = c_out; v = overflow;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'h1111; b = 16'h2222;
    step(); step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (result !== '0)      begin bad++; $display("FAIL reset_result got %h want 0000", result); end
    total++; if (c_out !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags got c=%b v=%b want 0 0", c_out, overflow);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5] = '{16'h1234, 16'h0005, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [W-1:0] vb [5] = '{16'h0FCD, 16'h0007, 16'h0001, 16'h0001, 16'h0001};
    logic         vs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] er [5] = '{16'h2201, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h0000};
    logic         ec [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic         ev [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] r;
    logic c, v;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], r, c, v, lat);
      total++; if (r !== er[i]) begin bad++; $display("FAIL dir%0d_result got %h want %h", i, r, er[i]); end
      total++; if (c !== ec[i]) begin bad++; $display("FAIL dir%0d_c_out got %b want %b", i, c, ec[i]); end
      total++; if (v !== ev[i]) begin bad++; $display("FAIL dir%0d_overflow got %b want %b", i, v, ev[i]); end
      total++; if (lat != 4)    begin bad++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, r;
    logic rs, c, v;
    logic [W+1:0] exp_v;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      exp_v = model(ra, rb, rs);
      run_op(ra, rb, rs, r, c, v, lat);
      total++;
      if (r !== exp_v[W-1:0] || c !== exp_v[W] || v !== exp_v[W+1] || lat != 4) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h sel=%b got r=%h c=%b v=%b lat=%0d want r=%h c=%b v=%b lat=4",
                 i, ra, rb, rs, r, c, v, lat, exp_v[W-1:0], exp_v[W], exp_v[W+1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp_v;
    int lat;
    exp_v = model(16'h4321, 16'h1234, 1'b1);
    a = 16'h4321; b = 16'h1234; sel = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    total++; if (lat != 4) begin bad++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = W'($urandom); b = W'($urandom);
      step();
      total++;
      if (result !== exp_v[W-1:0] || out_valid !== 1'b1 || in_ready !== 1'b0 || c_out !== exp_v[W]) begin
        bad++;
        $display("FAIL bp_hold%0d got r=%h ov=%b ir=%b c=%b want r=%h ov=1 ir=0 c=%b",
                 i, result, out_valid, in_ready, c_out, exp_v[W-1:0], exp_v[W]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== exp_v[W-1:0]) begin
      bad++;
      $display("FAIL bp_release got ov=%b ir=%b busy=%b r=%h want 0 1 0 %h",
               out_valid, in_ready, busy, result, exp_v[W-1:0]);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] r;
    logic c, v;
    int lat;
    a = 16'h00FF; b = 16'h0011; sel = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 ||
        c_out !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL abort_state got busy=%b ov=%b ir=%b r=%h c=%b v=%b want 0 0 1 0000 0 0",
               busy, out_valid, in_ready, result, c_out, overflow);
    end
    run_op(16'h0001, 16'h0001, 1'b0, r, c, v, lat);
    total++;
    if (r !== 16'h0002 || c !== 1'b0 || v !== 1'b0 || lat != 4) begin
      bad++;
      $display("FAIL abort_followup got r=%h c=%b v=%b lat=%0d want 0002 0 0 4", r, c, v, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] e1, e2;
    int lat, gap, want_gap;
`ifdef NIBSER_EARLY_ACCEPT_EN
    want_gap = 5;
`else
    want_gap = 6;
`endif
    e1 = model(16'h3A5C, 16'h1C3B, 1'b0);
    e2 = model(16'h0123, 16'h8F00, 1'b1);
    a = 16'h3A5C; b = 16'h1C3B; sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    a = 16'h0123; b = 16'h8F00; sel = 1'b1;
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    total++;
    if (result !== e1[W-1:0] || lat != 4) begin
      bad++; $display("FAIL b2b_first got r=%h lat=%0d want %h 4", result, lat, e1[W-1:0]);
    end
    gap = 0;
    do begin step(); gap++; end while (!out_valid && gap < 50);
    in_valid = 1'b0;
    total++;
    if (gap != want_gap) begin bad++; $display("FAIL b2b_gap got %0d want %0d", gap, want_gap); end
    total++;
    if (result !== e2[W-1:0] || c_out !== e2[W] || overflow !== e2[W+1]) begin
      bad++;
      $display("FAIL b2b_second got r=%h c=%b v=%b want %h %b %b",
               result, c_out, overflow, e2[W-1:0], e2[W], e2[W+1]);
    end
    step();
    out_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
Sequential WIDTH-bit add/subtract unit built around one 4-bit carry-lookahead add/sub slice, which it reuses over successive cycles.
- Processes one nibble per cycle, LSB nibble first, and carries between nibbles through a register.
- Sits directly upstream of the 4-bit slice: captures operands, sequences nibbles, registers carry and result, and presents a valid/ready result.
- Trades latency for area in the datapath.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8.
NIBBLES, WIDTH/4, derived localparam; number of RUN cycles.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  operand request.
in_ready  out  1  block can accept operands.
sel  in  1  0 = a+b, 1 = a−b.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  sum/difference.
c_out  out  1  final carry; for subtract, 1 = no borrow (a ≥ b unsigned).
overflow  out  1  two's-complement signed overflow.
busy  out  1  high in RUN or DONE.

Behaviour:
- One clock. Reset is synchronous, active-low; rst_n low at a clock edge overrides all other inputs.
- Reset values: state IDLE, idx 0, carry reg 0, result 0, c_out 0, overflow 0, out_valid 0, busy 0.
- in_ready = (state==IDLE); it reads 1 out of reset, but no accept occurs on an edge where rst_n is low.
- States are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: capture a, b, sel; carry_reg←sel; idx←0; result←0; go to RUN.
- RUN (in_ready=0, busy=1):
  - Each edge: slice inputs are a[4*idx+:4], b[4*idx+:4], sel, c_in=carry_reg.
  - Slice sum is written to result[4*idx+:4]; carry_reg←slice c_out; idx++.
  - At the edge processing idx=NIBBLES−1, go to DONE and latch c_out←slice c_out.
  - Latch overflow←(a_msb==beff_msb)&&(sum_msb!=a_msb), where beff = b^{WIDTH{sel}}.
- Latency: out_valid rises after edge T+NIBBLES (4 cycles for WIDTH=16).
- DONE:
  - out_valid=1; result, c_out and overflow are held stable while out_ready=0.
  - On out_ready: go to IDLE; out_valid←0. result, c_out and overflow keep their value until the next accept.
- in_valid while not IDLE is ignored; there is no queueing.
- Captured operands are unaffected by input changes after accept.
- Reset in RUN or DONE aborts the operation, returns to reset values, and discards the partial result.
- idx never wraps inside an operation; it is cleared on accept.

Optional Feature:
Macro NIBSER_EARLY_ACCEPT_EN.
- Defined: in_ready = IDLE || (DONE && out_ready). An accept in DONE performs result handoff and operand capture on the same edge and goes directly to RUN, giving back-to-back throughput of one op per NIBBLES+1 cycles. out_valid drops on that edge.
- Undefined: in_ready only in IDLE, giving throughput of one op per NIBBLES+2 cycles minimum.

Decomposition:
- Shared package/include nibser_pkg holds:
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - NIB_W=4;
  - function nibbles(width).
- One sub-module: the existing clas_4bit slice, instantiated once, with sel connected directly and c_in from carry_reg.
- FSM, counter and registers stay in nibble_serial_addsub.

Test Plan:
1. WIDTH=16, sel=0, a=0x1234, b=0x0FCD accepted at T → out_valid high after T+4; result=0x2201, c_out=0, overflow=0.
2. sel=1, a=0x0005, b=0x0007 → result=0xFFFE, c_out=0 (borrow), overflow=0.
3. sel=0, a=0x7FFF, b=0x0001 → result=0x8000, overflow=1, c_out=0; sel=1, a=0x8000, b=0x0001 → 0x7FFF, overflow=1, c_out=1.
4. sel=0, a=0xFFFF, b=0x0001 → result=0x0000, c_out=1, overflow=0 (carry ripples through all 4 nibble cycles).
5. Backpressure: out_ready=0 for 5 cycles in DONE with in_valid pulsing → result stable, in_ready=0, no new accept; out_ready=1 → IDLE next cycle, in_ready=1.
6. rst_n low for one edge after 2 RUN cycles → all outputs at reset values, state IDLE; a following a=0x0001, b=0x0001 add → 0x0002 correct. With NIBSER_EARLY_ACCEPT_EN: in_valid held high → second accept on the DONE/out_ready edge, result valid 5 cycles after the first out_valid.
